// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage: FSM state encoding,
// payload layout and jump/branch target formation.
package fetch_pkg;

  localparam int JUMP_INDEX_W = 26;
  localparam int INSTR_W      = 32;
  localparam int ADDR_W       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } fetchState_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pcPlus4;
  } fetchPayload_t;

  // J/JAL: the region bits come from the PC following the jump instruction.
  function automatic logic [ADDR_W-1:0] jump_target(
    input logic [ADDR_W-1:0]       pcPlus4,
    input logic [JUMP_INDEX_W-1:0] index
  );
    return {pcPlus4[ADDR_W-1:ADDR_W-4], index, 2'b00};
  endfunction

  function automatic logic [ADDR_W-1:0] branchAlign(input logic [ADDR_W-1:0] target);
    return {target[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_reg.sv
// Redirect arbitration (branch over jump), target formation, and a single-entry
// hold register for a redirect that arrives while a fetch request is outstanding.
module fetch_redirect_reg
  import fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    branchEn,
  input  logic [ADDR_W-1:0]       branchTarget,
  input  logic                    jumpEn,
  input  logic [JUMP_INDEX_W-1:0] jumpIndex,
  input  logic [ADDR_W-1:0]       pcPlus4Ref,
  input  logic                    holdEn,
  input  logic                    consumeEn,
  output logic                    redirectNow,
  output logic [ADDR_W-1:0]       target,
  output logic                    pending
);

  logic              pendValid;
  logic [ADDR_W-1:0] pendTarget;
  logic [ADDR_W-1:0] nowTarget;

  // The branch is the older instruction, so it beats a same-cycle jump.
  assign redirectNow = branchEn | jumpEn;
  assign nowTarget   = branchEn ? branchAlign(branchTarget) : jump_target(pcPlus4Ref, jumpIndex);
  assign target      = redirectNow ? nowTarget : pendTarget;
  assign pending     = pendValid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendValid  <= 1'b0;
      pendTarget <= '0;
    end else if (consumeEn) begin
      pendValid <= 1'b0;
    end else if (holdEn && redirectNow) begin
      pendValid  <= 1'b1;
      pendTarget <= nowTarget;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and hands
// {instr, pc, pc+4} to decode. Optional counters with FETCH_PERF_EN defined.
//
//   state | meaning
//   IDLE  | first cycle after reset release
//   REQ   | fetch request outstanding at pc
//   OUT   | payload presented to decode, waiting for handoff
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    jump_en,
  input  logic [JUMP_INDEX_W-1:0] jump_index,
  input  logic                    branch_en,
  input  logic [ADDR_W-1:0]       branch_target,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic                    if_valid,
  input  logic                    if_ready,
  output logic [INSTR_W-1:0]      if_instr,
  output logic [ADDR_W-1:0]       if_pc,
  output logic [ADDR_W-1:0]       if_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_squashed
`endif
);

  fetchState_e       state;
  fetchState_e       stateNext;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcPlus4;
  fetchPayload_t     payload;
  logic              payloadValid;

  logic              redirectNow;
  logic              pending;
  logic [ADDR_W-1:0] redirTarget;

  logic              ackInReq;
  logic              squash;
  logic              deliver;
  logic              redirectOut;
  logic              redirectIdle;
  logic              handoff;

  assign pcPlus4      = pc + 32'd4;
  assign ackInReq     = (state == REQ) && imem_ack;
  assign squash       = ackInReq && (redirectNow || pending);
  assign deliver      = ackInReq && !squash;
  assign redirectOut  = (state == OUT) && redirectNow;
  assign redirectIdle = (state == IDLE) && redirectNow;
  // A redirect in OUT drops the payload even when decode is ready.
  assign handoff      = (state == OUT) && if_ready && !stall && !redirectNow;

  fetch_redirect_reg u_redirect (
    .clk          (clk),
    .reset        (reset),
    .branchEn     (branch_en),
    .branchTarget (branch_target),
    .jumpEn       (jump_en),
    .jumpIndex    (jump_index),
    .pcPlus4Ref   (payload.pcPlus4),
    .holdEn       ((state == REQ) && !imem_ack),
    .consumeEn    (ackInReq),
    .redirectNow  (redirectNow),
    .target       (redirTarget),
    .pending      (pending)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = REQ;
      REQ:     if (deliver) stateNext = OUT;
      OUT:     if (handoff || redirectOut) stateNext = REQ;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    if (state == REQ) begin
      imem_req  = 1'b1;
      imem_addr = pc;
    end
  end

  // pc only moves on an ack or outside REQ, so the request address is stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (squash || redirectOut || redirectIdle) begin
      pc <= redirTarget;
    end else if (deliver) begin
      pc <= pcPlus4;
    end
  end

  // Payload fields are kept after handoff: the jump region comes from them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      payloadValid <= 1'b0;
      payload      <= '0;
    end else if (deliver) begin
      payloadValid    <= 1'b1;
      payload.instr   <= imem_rdata;
      payload.pc      <= pc;
      payload.pcPlus4 <= pcPlus4;
    end else if (handoff || redirectOut) begin
      payloadValid <= 1'b0;
    end
  end

  assign if_valid    = payloadValid;
  assign if_instr    = payload.instr;
  assign if_pc       = payload.pc;
  assign if_pc_plus4 = payload.pcPlus4;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (handoff) perf_fetched <= perf_fetched + 32'd1;
      if (squash)  perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the MIPS pipeline. Holds the PC and runs a req/ack fetch handshake with instruction memory.
- Delivers {instr, pc, pc_plus4} to decode over a valid/ready interface.
- Applies jump and branch redirects. Jump targets are formed internally as {pc_plus4[31:28], index, 2'b00}.
- It is the PC-owning end of jump-target formation: it consumes the target and produces the PC bits the target depends on.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall from decode; blocks handoff.
- jump_en  in  1  J/JAL redirect request (from ID).
- jump_index  in  26  instruction index field.
- branch_en  in  1  taken-branch/JR redirect (from EX).
- branch_target  in  32  full branch/JR target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  memory ack; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched word.
- if_valid  out  1  decode payload valid.
- if_ready  in  1  decode can accept.
- if_instr  out  32  instruction.
- if_pc  out  32  PC of if_instr.
- if_pc_plus4  out  32  if_pc + 4.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0, imem_addr=0, if_valid=0, if_instr/if_pc/if_pc_plus4=0.
  - pend_valid=0.
- States: IDLE, REQ, OUT.
  - IDLE -> REQ unconditionally on the first edge after reset release.
- REQ:
  - imem_req=1, imem_addr=pc.
  - Address held stable until the ack edge; the request is never withdrawn.
  - On imem_ack with no redirect and no pending redirect: capture rdata into if_instr, if_pc=pc, if_pc_plus4=pc+4; pc<=pc+4; if_valid<=1; go to OUT.
  - On imem_ack with a redirect this cycle or pend_valid=1: discard rdata (squash); pc<=target; pend_valid<=0; stay in REQ.
    - If both exist, the current-cycle redirect wins.
  - Redirect without ack: latch target into pend_target and set pend_valid=1. A later redirect overwrites it.
- OUT:
  - imem_req=0; payload held stable while if_valid=1 and not accepted.
  - Handoff occurs when if_ready=1 and stall=0: if_valid<=0; go to REQ.
  - Redirect in OUT: if_valid<=0 (payload dropped even if ready=1 that cycle); pc<=target; go to REQ.
- Latency: one fetch per ack, with one issue cycle in REQ. Best-case throughput is one instruction per 2 cycles. Single-entry buffer, no prefetch.
- Redirect targets:
  - jump: {pc_plus4_ref[31:28], jump_index, 2'b00}. pc_plus4_ref = if_pc_plus4 of the instruction in decode, i.e. the last payload presented.
  - branch: {branch_target[31:2], 2'b00}; low bits are forced to zero.
  - branch_en has priority over jump_en when both are asserted, because the branch is the older instruction.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC+4 = 0. A jump from if_pc=32'hFFFF_FFFC therefore uses region 4'h0.
- Reset mid-transaction: state returns to IDLE immediately. Memory must tolerate abandonment of an un-acked request.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro defined: adds outputs perf_fetched (32) and perf_squashed (32).
  - perf_fetched counts accepted handoffs; perf_squashed counts discarded acks.
  - Both reset to 0 and wrap on overflow.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, REQ, OUT};
  - JUMP_INDEX_W=26;
  - INSTR_W=32;
  - function jump_target(pc_plus4, index).
- Sub-module: fetch_redirect_reg. It arbitrates branch over jump, forms the target, and holds pend_valid/pend_target. Outputs are redirect_now, target, and pending.

Test Plan:
- Reset release, imem_ack on the first REQ cycle, rdata=32'h2002_0005, if_ready=1:
  - imem_addr=0x0;
  - if_valid=1 with if_pc=0x0 and if_pc_plus4=0x4;
  - next request address 0x4.
- if_ready=0 for 3 cycles in OUT: payload stable, imem_req=0. Handoff on ready; next imem_addr=pc+4.
- jump_en with index=26'h000_0010 while if_pc_plus4=0x4000_0008: next imem_addr=0x4000_0040.
- branch_en with target=0x0000_0103 during an un-acked REQ at 0x20:
  - imem_addr stays 0x20 until ack;
  - that ack is squashed (if_valid stays 0);
  - next imem_addr=0x100.
- branch_en=1 and jump_en=1 in the same cycle: the branch target is used.
- Fetch at 0xFFFF_FFFC: if_pc_plus4=0x0. Jump index 1 from that instruction: target 0x0000_0004.
